// File: rtl/trace_feeder.sv
// ---------------------------------------------------------------------------
// trace_feeder
//
// Purpose:
//   Takes a stream of memory-trace entries ({write flag, byte address}),
//   discards zero-address entries (address 0 is the cache's idle code),
//   buffers the rest in a small FIFO and presents them one at a time to a
//   cache stage through a registered valid/ready output stage. Issued reads,
//   issued writes and dropped entries are counted with saturating counters.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   OFFSET_BITS  block-offset bits of the address
//   INDEX_BITS   set-index bits of the address
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-high reset
//   in_valid     trace entry present
//   in_ready     feeder accepts an entry this cycle
//   in_write     1 = write access, 0 = read access
//   in_addr      byte address of the access
//   flush        synchronous clear of all queued work
//   out_valid    request presented to the cache stage
//   out_ready    cache stage consumes the request
//   out_write    read/write flag of the presented request
//   out_addr     byte address of the presented request
//   out_tag      tag slice of out_addr
//   out_index    set-index slice of out_addr
//   num_reads    issued read requests (saturating)
//   num_writes   issued write requests (saturating)
//   num_dropped  discarded zero-address entries (saturating)
//   full         FIFO holds DEPTH entries
//   empty        FIFO and output stage both hold nothing
// ---------------------------------------------------------------------------
module trace_feeder #(
  parameter int DEPTH       = 4,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_write,
  input  logic [31:0]                         in_addr,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_write,
  output logic [31:0]                         out_addr,
  output logic [31-OFFSET_BITS-INDEX_BITS:0]  out_tag,
  output logic [INDEX_BITS-1:0]               out_index,
  output logic [11:0]                         num_reads,
  output logic [11:0]                         num_writes,
  output logic [7:0]                          num_dropped,
  output logic                                full,
  output logic                                empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TAG_LSB = OFFSET_BITS + INDEX_BITS;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_t;

  // FIFO storage: bit 32 is the write flag, bits 31:0 the address.
  logic [32:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Output stage
  out_state_t       state_reg;
  out_state_t       state_next;
  logic [31:0]      out_addr_reg;
  logic             out_write_reg;

  // Counters
  logic [11:0]      rd_cnt_reg;
  logic [11:0]      wr_cnt_reg;
  logic [7:0]       drop_cnt_reg;

  // Goes high on the first edge after reset is released; keeps in_ready low
  // while reset is asserted and for the remainder of that cycle.
  logic             live_reg;

  logic             fifo_full;
  logic             fifo_nonempty;
  logic             accept;
  logic             push;
  logic             drop;
  logic             pop;
  logic             out_fire;
  logic [32:0]      head_entry;

  // -------------------------------------------------------------------------
  // Handshake decode (occupancy is registered, so in_ready has no path from
  // in_valid or out_ready)
  // -------------------------------------------------------------------------
  assign fifo_full     = (count_reg == CNT_W'(DEPTH));
  assign fifo_nonempty = (count_reg != '0);

  assign in_ready = live_reg && !fifo_full && !flush;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (in_addr != 32'd0);
  assign drop     = accept && (in_addr == 32'd0);
  assign out_fire = (state_reg == OUT_HOLD) && out_ready;

  assign head_entry = mem[rd_ptr_reg];

  // -------------------------------------------------------------------------
  // Output-stage FSM: next state and FIFO pop decision
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      OUT_EMPTY: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          state_next = OUT_HOLD;
        end
      end
      OUT_HOLD: begin
        if (out_ready) begin
          if (fifo_nonempty) begin
            pop        = 1'b1;
            state_next = OUT_HOLD;
          end else begin
            state_next = OUT_EMPTY;
          end
        end
      end
      default: begin
        state_next = OUT_EMPTY;
      end
    endcase
    // Flush discards the FIFO contents, so nothing is loaded from it.
    if (flush) begin
      pop        = 1'b0;
      state_next = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= OUT_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage (no reset: contents are only meaningful under count_reg)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_write, in_addr};
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy. DEPTH is a power of two, so the pointers
  // wrap naturally at their width.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output register: loaded only on a pop, otherwise held stable
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_addr_reg  <= 32'd0;
      out_write_reg <= 1'b0;
    end else if (pop) begin
      out_addr_reg  <= head_entry[31:0];
      out_write_reg <= head_entry[32];
    end
  end

  // -------------------------------------------------------------------------
  // Saturating counters. They are not affected by flush, and an output
  // handshake on the same edge as a flush still counts.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_reg   <= 12'd0;
      wr_cnt_reg   <= 12'd0;
      drop_cnt_reg <= 8'd0;
    end else begin
      if (out_fire) begin
        if (out_write_reg) begin
          if (wr_cnt_reg != 12'hFFF) begin
            wr_cnt_reg <= wr_cnt_reg + 1'b1;
          end
        end else begin
          if (rd_cnt_reg != 12'hFFF) begin
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
          end
        end
      end
      if (drop && (drop_cnt_reg != 8'hFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_reg <= 1'b0;
    end else begin
      live_reg <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid   = (state_reg == OUT_HOLD);
  assign out_addr    = out_addr_reg;
  assign out_write   = out_write_reg;
  assign out_tag     = out_addr_reg[31:TAG_LSB];
  assign out_index   = out_addr_reg[TAG_LSB-1:OFFSET_BITS];
  assign num_reads   = rd_cnt_reg;
  assign num_writes  = wr_cnt_reg;
  assign num_dropped = drop_cnt_reg;
  assign full        = fifo_full;
  assign empty       = !fifo_nonempty && (state_reg == OUT_EMPTY);

endmodule
